clock_enable_gen: RTL

Multi-channel, parametrised clock-enable generator for the snake display and game logic. Runs entirely on the 100 MHz system clock and produces single-cycle `tick` strobes at programmable divide ratios, for example 25 MHz pixel enable and slow game-step enable. Downstream logic stays in one clock domain and uses the strobes as enables; no derived or ripple clocks leave this block. Each channel's divisor is reloadable at run time, and a reload takes effect without glitching the current period.

---
 rtl/clken_pkg.sv | 11 +
 rtl/clken_channel.sv | 74 +++++++
 rtl/clock_enable_gen.sv | 55 +++++
 3 files changed

// File: rtl/clken_pkg.sv
// Shared constants and helpers for the clock-enable generator.
package clken_pkg;

    localparam int unsigned DEFAULT_DIV = 4;

    // A zero divisor would never wrap, so it is stored as 1 (tick every cycle).
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d == '0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/clken_channel.sv
// One enable channel: counter, active/pending divisor, tick strobe.
// Optional square output when CLKEN_SQUARE_OUT_EN is defined.
module clken_channel #(
    parameter int unsigned WIDTH       = 24,
    parameter int unsigned DEFAULT_DIV = clken_pkg::DEFAULT_DIV
) (
    input  logic             clock100,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] div_in,
    input  logic             load,
    output logic             tick,
    output logic             load_pending
`ifdef CLKEN_SQUARE_OUT_EN
    ,
    output logic             sq
`endif
);
    import clken_pkg::*;

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(clamp_div(32'(DEFAULT_DIV)));

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_pend;
    logic [WIDTH-1:0] div_clamped;
    logic             pend;
    logic             wrap;

    assign div_clamped  = WIDTH'(clamp_div(32'(div_in)));
    assign wrap         = run && (cnt == div_act - WIDTH'(1));
    assign load_pending = pend;

    always_ff @(posedge clock100 or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            div_act  <= RESET_DIV;
            div_pend <= RESET_DIV;
            pend     <= 1'b0;
            tick     <= 1'b0;
`ifdef CLKEN_SQUARE_OUT_EN
            sq       <= 1'b0;
`endif
        end else begin
            tick <= wrap;
            if (run) begin
                if (wrap) begin
                    cnt <= '0;
                    if (pend) begin
                        div_act <= div_pend;
                        pend    <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + WIDTH'(1);
                end
            end else if (pend) begin
                div_act <= div_pend;
                cnt     <= '0;
                pend    <= 1'b0;
            end
            // A coincident load lands after the apply, so it waits for the next one.
            if (load) begin
                div_pend <= div_clamped;
                pend     <= 1'b1;
            end
`ifdef CLKEN_SQUARE_OUT_EN
            if (wrap) begin
                sq <= ~sq;
            end
`endif
        end
    end

endmodule

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator on the 100 MHz system clock.
// Define CLKEN_SQUARE_OUT_EN to add the 50 % duty sq outputs.
module clock_enable_gen #(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned WIDTH       = 24,
    parameter int unsigned DEFAULT_DIV = clken_pkg::DEFAULT_DIV,
    localparam int unsigned SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock100,
    input  logic                reset,
    input  logic [CHANNELS-1:0] run,
    input  logic [WIDTH-1:0]    div_in,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic                div_load,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] load_pending
`ifdef CLKEN_SQUARE_OUT_EN
    ,
    output logic [CHANNELS-1:0] sq
`endif
);
    import clken_pkg::*;

    logic [CHANNELS-1:0] load;

    // Selects at or above CHANNELS match no channel, so such loads are dropped.
    always_comb begin
        load = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (div_load && (32'(div_sel) == i)) begin
                load[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
        clken_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clock100     (clock100),
            .reset        (reset),
            .run          (run[g]),
            .div_in       (div_in),
            .load         (load[g]),
            .tick         (tick[g]),
            .load_pending (load_pending[g])
`ifdef CLKEN_SQUARE_OUT_EN
            ,
            .sq           (sq[g])
`endif
        );
    end

endmodule
